// File: rtl/csr_unit.sv
// Machine-mode CSR unit: atomic RW/RS/RC access, trap entry and MRET, WARL fields, 64-bit counters.
// Optional counters (mcycle/minstret/mcountinhibit) are built only when TCORE_CSR_COUNTERS_EN is defined.
module csr_unit #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MISA_VAL  = 32'h4000_1104,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            csr_en_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_idx_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            instr_ret_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] trap_vec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_glob_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MCNTINH  = 12'h320;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRTH = 12'hB82;
  localparam logic [11:0] A_MVENDOR  = 12'hF11;
  localparam logic [11:0] A_MARCH    = 12'hF12;
  localparam logic [11:0] A_MIMP     = 12'hF13;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  // WARL legalisation helpers
  function automatic logic [31:0] legal_mtvec(input logic [31:0] w);
    return {w[31:2], (w[1] ? 2'b00 : w[1:0])};
  endfunction

  function automatic logic [31:0] legal_irq(input logic [31:0] w);
    return w & 32'h0000_0888;
  endfunction

  function automatic logic [31:0] legal_inhibit(input logic [31:0] w);
    return w & 32'h0000_0005;
  endfunction

  logic        st_mie, st_mpie;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mie_q, mip_q;
  logic [31:0] cyc_lo, cyc_hi, ret_lo, ret_hi, inhibit;
  logic [31:0] old_val, new_val, mstatus_val;
  logic        impl, wr_req, wr_en;

  assign mstatus_val = {19'd0, 2'b11, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};

  always_comb begin
    old_val = '0;
    impl    = 1'b1;
    case (csr_idx_i)
      A_MVENDOR, A_MARCH, A_MIMP: old_val = '0;
      A_MHARTID:  old_val = HART_ID;
      A_MISA:     old_val = MISA_VAL;
      A_MSTATUS:  old_val = mstatus_val;
      A_MIE:      old_val = mie_q;
      A_MTVEC:    old_val = mtvec_q;
      A_MSCRATCH: old_val = mscratch_q;
      A_MEPC:     old_val = mepc_q;
      A_MCAUSE:   old_val = mcause_q;
      A_MTVAL:    old_val = mtval_q;
      A_MIP:      old_val = mip_q;
      A_MCYCLE:   old_val = cyc_lo;
      A_MCYCLEH:  old_val = cyc_hi;
      A_MINSTRET: old_val = ret_lo;
      A_MINSTRTH: old_val = ret_hi;
      A_MCNTINH:  old_val = inhibit;
      default:    impl    = 1'b0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (csr_op_i)
      2'b01:   new_val = csr_wdata_i;
      2'b10:   new_val = old_val | csr_wdata_i;
      2'b11:   new_val = old_val & ~csr_wdata_i;
      default: new_val = old_val;
    endcase
  end

  // RW always writes; RS/RC only with a non-zero operand; op 00 never writes
  assign wr_req        = csr_en_i && ((csr_op_i == 2'b01) ||
                                      (csr_op_i[1] && (csr_wdata_i != '0)));
  assign csr_illegal_o = csr_en_i && (!impl || ((csr_idx_i[11:10] == 2'b11) && wr_req));
  assign wr_en         = wr_req && !csr_illegal_o;
  assign csr_rdata_o   = csr_en_i ? old_val : '0;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval, wr_mip;
  assign wr_mstatus  = wr_en && (csr_idx_i == A_MSTATUS);
  assign wr_mie      = wr_en && (csr_idx_i == A_MIE);
  assign wr_mtvec    = wr_en && (csr_idx_i == A_MTVEC);
  assign wr_mscratch = wr_en && (csr_idx_i == A_MSCRATCH);
  assign wr_mepc     = wr_en && (csr_idx_i == A_MEPC);
  assign wr_mcause   = wr_en && (csr_idx_i == A_MCAUSE);
  assign wr_mtval    = wr_en && (csr_idx_i == A_MTVAL);
  assign wr_mip      = wr_en && (csr_idx_i == A_MIP);

  // Trap state beats MRET, which beats a software write to the same register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mie_q      <= '0;
      mip_q      <= '0;
    end else begin
      if (trap_i) begin
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
        mepc_q   <= {trap_pc_i[31:1], 1'b0};
        mcause_q <= trap_cause_i;
        mtval_q  <= trap_tval_i;
      end else begin
        if (mret_i) begin
          st_mie  <= st_mpie;
          st_mpie <= 1'b1;
        end else if (wr_mstatus) begin
          st_mie  <= new_val[3];
          st_mpie <= new_val[7];
        end
        if (wr_mepc)   mepc_q   <= {new_val[31:1], 1'b0};
        if (wr_mcause) mcause_q <= new_val;
        if (wr_mtval)  mtval_q  <= new_val;
      end
      if (wr_mtvec)    mtvec_q    <= legal_mtvec(new_val);
      if (wr_mscratch) mscratch_q <= new_val;
      if (wr_mie)      mie_q      <= legal_irq(new_val);
      if (wr_mip)      mip_q      <= legal_irq(new_val);
    end
  end

`ifdef TCORE_CSR_COUNTERS_EN
  logic [31:0] cyc_lo_q, cyc_hi_q, ret_lo_q, ret_hi_q, inhibit_q;
  logic [63:0] cyc_sum, ret_sum;
  logic        wr_cyc_lo, wr_cyc_hi, wr_ret_lo, wr_ret_hi, wr_inh;

  assign wr_cyc_lo = wr_en && (csr_idx_i == A_MCYCLE);
  assign wr_cyc_hi = wr_en && (csr_idx_i == A_MCYCLEH);
  assign wr_ret_lo = wr_en && (csr_idx_i == A_MINSTRET);
  assign wr_ret_hi = wr_en && (csr_idx_i == A_MINSTRTH);
  assign wr_inh    = wr_en && (csr_idx_i == A_MCNTINH);

  assign cyc_sum = {cyc_hi_q, cyc_lo_q} + {63'd0, ~inhibit_q[0]};
  assign ret_sum = {ret_hi_q, ret_lo_q} + {63'd0, instr_ret_i & ~inhibit_q[2]};

  // Writing one half replaces the increment; the untouched half advances without the carry
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_lo_q  <= '0;
      cyc_hi_q  <= '0;
      ret_lo_q  <= '0;
      ret_hi_q  <= '0;
      inhibit_q <= '0;
    end else begin
      cyc_lo_q <= wr_cyc_lo ? new_val : cyc_sum[31:0];
      cyc_hi_q <= wr_cyc_hi ? new_val : (wr_cyc_lo ? cyc_hi_q : cyc_sum[63:32]);
      ret_lo_q <= wr_ret_lo ? new_val : ret_sum[31:0];
      ret_hi_q <= wr_ret_hi ? new_val : (wr_ret_lo ? ret_hi_q : ret_sum[63:32]);
      if (wr_inh) inhibit_q <= legal_inhibit(new_val);
    end
  end

  assign cyc_lo  = cyc_lo_q;
  assign cyc_hi  = cyc_hi_q;
  assign ret_lo  = ret_lo_q;
  assign ret_hi  = ret_hi_q;
  assign inhibit = inhibit_q;
`else
  logic unused_instr_ret;
  assign unused_instr_ret = instr_ret_i;
  assign cyc_lo  = '0;
  assign cyc_hi  = '0;
  assign ret_lo  = '0;
  assign ret_hi  = '0;
  assign inhibit = legal_inhibit('0);
`endif

  // Vectored mode only applies to interrupts
  always_comb begin
    trap_vec_o = {mtvec_q[31:2], 2'b00};
    if ((mtvec_q[1:0] == 2'b01) && trap_cause_i[31])
      trap_vec_o = {mtvec_q[31:2], 2'b00} + {25'd0, trap_cause_i[4:0], 2'b00};
  end

  assign mepc_o     = mepc_q;
  assign mie_glob_o = st_mie;

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit; counter checks follow TCORE_CSR_COUNTERS_EN.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_idx;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        instr_ret;
  logic        trap;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        mret;
  logic [31:0] trap_vec, mepc;
  logic        mie_glob;

  int n_cmp = 0;
  int n_err = 0;

  csr_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .csr_en_i     (csr_en),
    .csr_op_i     (csr_op),
    .csr_idx_i    (csr_idx),
    .csr_wdata_i  (csr_wdata),
    .csr_rdata_o  (csr_rdata),
    .csr_illegal_o(csr_illegal),
    .instr_ret_i  (instr_ret),
    .trap_i       (trap),
    .trap_cause_i (trap_cause),
    .trap_pc_i    (trap_pc),
    .trap_tval_i  (trap_tval),
    .mret_i       (mret),
    .trap_vec_o   (trap_vec),
    .mepc_o       (mepc),
    .mie_glob_o   (mie_glob)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; the write commits on the next edge
  task automatic access(input string tag, input logic [1:0] op, input logic [11:0] idx,
                        input logic [31:0] wd, input logic exp_ill);
    csr_en = 1'b1; csr_op = op; csr_idx = idx; csr_wdata = wd;
    #1;
    check({tag, "_ill"}, {31'd0, csr_illegal}, {31'd0, exp_ill});
    @(posedge clk); #1;
    csr_en = 1'b0; csr_op = 2'b00; csr_wdata = '0;
  endtask

  task automatic rd(input string tag, input logic [11:0] idx, input logic [31:0] exp);
    csr_en = 1'b1; csr_op = 2'b00; csr_idx = idx; csr_wdata = '0;
    #1;
    check(tag, csr_rdata, exp);
    csr_en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; csr_en = 1'b0; csr_op = 2'b00; csr_idx = '0; csr_wdata = '0;
    instr_ret = 1'b0; trap = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0; mret = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_mepc", mepc, 32'h0);
    check("rst_mie_glob", {31'd0, mie_glob}, 32'h0);
    check("rdata_idle", csr_rdata, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mtvec", 12'h305, 32'h0);
    rd("misa", 12'h301, 32'h4000_1104);
    rd("mhartid", 12'hF14, 32'h0);

    // mtvec WARL and trap vector
    access("mtvec_w1", 2'b01, 12'h305, 32'h8000_0003, 1'b0);
    rd("mtvec_legal", 12'h305, 32'h8000_0000);
    trap_cause = 32'h8000_0007; #1;
    check("vec_direct", trap_vec, 32'h8000_0000);
    access("mtvec_w2", 2'b01, 12'h305, 32'h8000_0001, 1'b0);
    check("vec_vectored", trap_vec, 32'h8000_001C);
    trap_cause = 32'h0000_0002; #1;
    check("vec_exception", trap_vec, 32'h8000_0000);

    // Trap entry and MRET
    access("mstatus_rs", 2'b10, 12'h300, 32'h8, 1'b0);
    check("mie_set", {31'd0, mie_glob}, 32'h1);
    trap = 1'b1; trap_pc = 32'h0000_1235; trap_cause = 32'h2; trap_tval = 32'hDEAD;
    @(posedge clk); #1 trap = 1'b0;
    check("trap_mepc", mepc, 32'h0000_1234);
    check("trap_mie", {31'd0, mie_glob}, 32'h0);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    rd("trap_mcause", 12'h342, 32'h2);
    rd("trap_mtval", 12'h343, 32'hDEAD);
    mret = 1'b1;
    @(posedge clk); #1 mret = 1'b0;
    check("mret_mie", {31'd0, mie_glob}, 32'h1);
    rd("mret_mstatus", 12'h300, 32'h0000_1888);

    // Atomic ops and illegal accesses
    access("scr_rw", 2'b01, 12'h340, 32'hF0, 1'b0);
    access("scr_rs", 2'b10, 12'h340, 32'h0F, 1'b0);
    rd("scr_after_rs", 12'h340, 32'hFF);
    access("scr_rc", 2'b11, 12'h340, 32'h0F, 1'b0);
    rd("scr_after_rc", 12'h340, 32'hF0);
    access("scr_rs0", 2'b10, 12'h340, 32'h0, 1'b0);
    rd("scr_rs0_keep", 12'h340, 32'hF0);
    access("ro_write", 2'b01, 12'hF11, 32'h5, 1'b1);
    rd("ro_unchanged", 12'hF11, 32'h0);
    access("ro_read", 2'b00, 12'hF11, 32'h0, 1'b0);
    access("ro_rs0", 2'b10, 12'hF11, 32'h0, 1'b0);
    access("unimpl", 2'b00, 12'h7C0, 32'h0, 1'b1);
    access("misa_w", 2'b01, 12'h301, 32'h0, 1'b0);
    rd("misa_kept", 12'h301, 32'h4000_1104);
    access("mie_w", 2'b01, 12'h304, 32'hFFFF_FFFF, 1'b0);
    rd("mie_legal", 12'h304, 32'h0000_0888);
    access("mip_w", 2'b01, 12'h344, 32'hFFFF_FFFF, 1'b0);
    rd("mip_legal", 12'h344, 32'h0000_0888);
    access("mepc_w", 2'b01, 12'h341, 32'h0000_0101, 1'b0);
    check("mepc_bit0", mepc, 32'h0000_0100);

`ifdef TCORE_CSR_COUNTERS_EN
    access("ret_w", 2'b01, 12'hB02, 32'h10, 1'b0);
    instr_ret = 1'b1;
    repeat (3) @(posedge clk);
    #1 instr_ret = 1'b0;
    rd("ret_count", 12'hB02, 32'h13);
    access("cyc_lo_w", 2'b01, 12'hB00, 32'hFFFF_FFFE, 1'b0);
    access("cyc_hi_w", 2'b01, 12'hB80, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rd("cyc_lo_wrap", 12'hB00, 32'h1);
    rd("cyc_hi_carry", 12'hB80, 32'h1);
    access("inh_w", 2'b01, 12'h320, 32'hFF, 1'b0);
    rd("inh_legal", 12'h320, 32'h5);
    instr_ret = 1'b1;
    repeat (2) @(posedge clk);
    #1 instr_ret = 1'b0;
    rd("cyc_frozen", 12'hB00, 32'h4);
    rd("cyc_hi_frozen", 12'hB80, 32'h1);
    rd("ret_frozen", 12'hB02, 32'h13);
`else
    access("cyc_w_ignored", 2'b01, 12'hB00, 32'h1234, 1'b0);
    rd("cyc_reads0", 12'hB00, 32'h0);
    access("inh_w_ignored", 2'b01, 12'h320, 32'h5, 1'b0);
    rd("inh_reads0", 12'h320, 32'h0);
    rd("reth_reads0", 12'hB82, 32'h0);
`endif

    // Trap beats a same-cycle mepc write
    csr_en = 1'b1; csr_op = 2'b01; csr_idx = 12'h341; csr_wdata = 32'h100;
    trap = 1'b1; trap_pc = 32'h2000; trap_cause = 32'hB; trap_tval = 32'h0;
    @(posedge clk); #1;
    csr_en = 1'b0; trap = 1'b0;
    check("trap_vs_write", mepc, 32'h2000);
    rd("trap2_mcause", 12'h342, 32'hB);

    // MRET beats a same-cycle mstatus write
    csr_en = 1'b1; csr_op = 2'b01; csr_idx = 12'h300; csr_wdata = 32'h0; mret = 1'b1;
    @(posedge clk); #1;
    csr_en = 1'b0; mret = 1'b0;
    rd("mret_vs_write", 12'h300, 32'h0000_1888);

    // Reset beats a same-cycle trap
    access("scr_pre", 2'b01, 12'h340, 32'hABCD, 1'b0);
    rst = 1'b1; trap = 1'b1; trap_pc = 32'h3000; trap_cause = 32'h5; trap_tval = 32'h77;
    @(posedge clk); #1;
    rst = 1'b0; trap = 1'b0;
    check("rst2_mepc", mepc, 32'h0);
    check("rst2_mie", {31'd0, mie_glob}, 32'h0);
    rd("rst2_mstatus", 12'h300, 32'h0000_1800);
    rd("rst2_mtvec", 12'h305, 32'h0);
    rd("rst2_mscratch", 12'h340, 32'h0);
    rd("rst2_mcause", 12'h342, 32'h0);
    rd("rst2_mtval", 12'h343, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
Parametrised machine-mode CSR unit, successor to the core's plain CSR register file.
- Adds atomic CSR ops (RW/RS/RC) and illegal-access detection.
- Adds hardware trap entry/MRET state stacking and free-running 64-bit counters with inhibit.
- Adds WARL field legalisation and trap-vector computation.
- Sits beside the execute stage; the pipeline drives access, retire, trap and mret strobes.

Parameters:
- XLEN, 32, data width (only 32 supported)
- HART_ID, 0, value read from mhartid
- MISA_VAL, 32'h4000_1104, read-only misa value (RV32IMC)
- MTVEC_RST, 32'h0000_0000, mtvec reset value

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- csr_en_i  in  1  CSR instruction valid this cycle
- csr_op_i  in  2  01=RW, 10=RS (set), 11=RC (clear), 00=read-only access
- csr_idx_i  in  12  CSR address
- csr_wdata_i  in  XLEN  rs1/imm operand
- csr_rdata_o  out  XLEN  old CSR value, combinational
- csr_illegal_o  out  1  illegal access, combinational
- instr_ret_i  in  1  one instruction retired
- trap_i  in  1  take trap this cycle
- trap_cause_i  in  XLEN  mcause value (bit31 = interrupt)
- trap_pc_i  in  XLEN  faulting PC
- trap_tval_i  in  XLEN  mtval value
- mret_i  in  1  MRET executing
- trap_vec_o  out  XLEN  trap target PC, combinational
- mepc_o  out  XLEN  current mepc
- mie_glob_o  out  1  mstatus.MIE

Behaviour:
- Implemented CSRs: mvendorid, marchid, mimpid (read 0), mhartid (HART_ID), misa, mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip, mcycle/h, minstret/h, mcountinhibit.
- Read: csr_rdata_o = CSR value when csr_en_i, else 0. Unimplemented index reads 0.
- New value:
  - RW: wdata
  - RS: old | wdata
  - RC: old & ~wdata
- Write commits on the next clk_i edge.
- RS/RC with wdata==0 and op 00 perform no write.
- csr_illegal_o=1 when csr_en_i and either:
  - index is unimplemented, or
  - idx[11:10]==2'b11 and a write would occur.
- An illegal access suppresses the write.
- misa writes are legal but ignored.
- WARL legalisation:
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; other bits read 0.
  - mtvec: MODE[1:0] values 1x are stored as 00.
  - mepc: bit0 is forced to 0.
  - mie/mip: only bits 3, 7, 11 are writable.
  - mcountinhibit: only bits 0 and 2 are writable.
- Priority in one cycle: rst_i > trap_i > mret_i > CSR write. A lower-priority write to a register touched by a higher-priority event is dropped.
- Trap entry:
  - MPIE<=MIE, MIE<=0
  - mepc<=trap_pc_i & ~1
  - mcause<=trap_cause_i
  - mtval<=trap_tval_i
- MRET: MIE<=MPIE, MPIE<=1.
- trap_vec_o:
  - mtvec base {[31:2],2'b00} + 4*trap_cause_i[4:0] when MODE==01 and trap_cause_i[31]==1.
  - Otherwise the base.
  - 32-bit wrap-around.
- Counters:
  - mcycle (64-bit) +1 every cycle unless mcountinhibit[0].
  - minstret (64-bit) +1 on instr_ret_i unless mcountinhibit[2].
  - Carry from low to high half is in the same cycle; 2^64-1 wraps to 0.
  - A CSR write to either half wins over that cycle's increment. The other half keeps the value it would have had without the write, carry excluded.
- Reset values:
  - mstatus MIE=MPIE=0
  - mtvec=MTVEC_RST
  - all other registers 0
  - outputs: mepc_o=0, mie_glob_o=0
- Reset asserted mid-operation overrides every pending event that cycle.

Optional Feature:
- Macro: TCORE_CSR_COUNTERS_EN
- Defined: mcycle/minstret/mcountinhibit behave as above.
- Undefined:
  - Counter registers are not instantiated.
  - Their indices read 0 and are legal.
  - Writes to them are silently ignored.

Test Plan:
- After reset, RW mtvec with 0x8000_0003; read mtvec -> 0x8000_0000; trap_cause 0x8000_0007 -> trap_vec_o 0x8000_0000.
- Write mtvec 0x8000_0001; trap_cause 0x8000_0007 -> trap_vec_o 0x8000_001C; trap_cause 0x0000_0002 -> 0x8000_0000.
- mstatus.MIE=1; trap_i with pc 0x0000_1235, cause 2, tval 0xDEAD -> mepc 0x1234, MIE=0, MPIE=1, mstatus reads 0x1880. Then mret_i -> MIE=1, mstatus reads 0x1888.
- RS mscratch 0x0F after RW 0xF0 -> reads 0xFF; RC with 0x0F -> 0xF0. Write to 0xF11 -> csr_illegal_o=1, no change. Access to 0x7C0 -> illegal.
- Write mcycle 0xFFFF_FFFE, mcycleh 0; after 3 cycles -> mcycleh=1, mcycle=1. Set mcountinhibit=0x5 -> both counters freeze.
- trap_i and RW mepc 0x100 in the same cycle -> mepc takes trap_pc_i. rst_i with trap_i -> all reset values.
